// File: rtl/iterative_shift_unit.sv
// -----------------------------------------------------------------------------
// iterative_shift_unit
//
// Multi-cycle shift/rotate unit. An operation is launched with start in IDLE,
// walks the working register STEP bits (or fewer) per cycle in SHIFT, and
// finishes with a single-cycle done pulse in DONE.
//
// Handshake: start is sampled only while the unit is idle (busy=0, done=0).
// When accepted, busy is high for every SHIFT cycle. done is high for exactly
// one cycle, during which result/carry are final. They then hold until the
// next accepted start. Requests made while busy or in DONE are dropped.
// kill aborts a running shift (no done pulse) and is ignored otherwise.
//
// Ports:
//   clock     - system clock, rising edge
//   clear     - synchronous active-high reset
//   start     - launch request (sampled in IDLE only)
//   kill      - synchronous abort of a running shift
//   op        - 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others illegal
//   a         - operand
//   amt       - shift amount 0..WIDTH-1
//   busy      - high while shifting
//   done      - one-cycle completion pulse
//   result    - working register (intermediate values visible while busy)
//   carry     - last bit shifted out (0 for rotates and zero-length ops)
//   zero      - result == 0
//   neg       - result MSB
//   dbg_state - FSM state: 0 IDLE, 1 SHIFT, 2 DONE
// -----------------------------------------------------------------------------
module iterative_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [CNT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  localparam logic [CNT_W-1:0] STEP_AMT = CNT_W'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  // Per-cycle shift datapath
  logic [CNT_W-1:0] step_amt;
  logic [CNT_W-1:0] rot_amt;
  logic [WIDTH-1:0] out_lsb;
  logic [WIDTH-1:0] out_msb;
  logic [WIDTH-1:0] shifted;
  logic             shift_cout;

  always_comb begin
    step_amt   = (remaining_q < STEP_AMT) ? remaining_q : STEP_AMT;
    // WIDTH is a power of two, so WIDTH-s wraps cleanly in CNT_W bits.
    // step_amt is never zero inside SHIFT, so rot_amt is in 1..WIDTH-1.
    rot_amt    = -step_amt;
    // Bring the last bit to leave the register into a fixed position.
    out_lsb    = result_q >> (step_amt - CNT_W'(1));
    out_msb    = result_q << (step_amt - CNT_W'(1));
    shifted    = result_q;
    shift_cout = carry_q;
    case (op_q)
      OP_SHR: begin
        shifted    = result_q >> step_amt;
        shift_cout = out_lsb[0];
      end
      OP_SHRA: begin
        // The MSB never changes under arithmetic shift, so it stays equal to
        // the original sign bit for the whole operation.
        shifted    = $signed(result_q) >>> step_amt;
        shift_cout = out_lsb[0];
      end
      OP_SHL: begin
        shifted    = result_q << step_amt;
        shift_cout = out_msb[WIDTH-1];
      end
      OP_ROR: begin
        shifted    = (result_q >> step_amt) | (result_q << rot_amt);
      end
      OP_ROL: begin
        shifted    = (result_q << step_amt) | (result_q >> rot_amt);
      end
      default: begin
        shifted    = result_q;
      end
    endcase
  end

  // Next-state / register update
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    carry_d     = carry_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        // start beats kill here; kill has no meaning while idle.
        if (start) begin
          result_d    = a;
          carry_d     = 1'b0;
          op_d        = op;
          remaining_d = amt;
          if ((amt == '0) || (op > OP_ROL)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (kill) begin
          // Partial result and carry are left as they are.
          state_d = ST_IDLE;
        end else begin
          result_d    = shifted;
          carry_d     = shift_cout;
          remaining_d = remaining_q - step_amt;
          if (remaining_q == step_amt) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      carry_q     <= 1'b0;
      op_q        <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = (result_q == '0);
  assign neg       = result_q[WIDTH-1];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_iterative_shift_unit
//
// Two instances (STEP=1 and STEP=4, WIDTH=32) share clock, clear and all
// inputs, so every operation exercises both latencies at once. Expected
// results come from a whole-word arithmetic model of each mode; expected
// timing comes from ceil(n/STEP).
// -----------------------------------------------------------------------------
module tb_iterative_shift_unit;

  localparam int W     = 32;
  localparam int CW    = 5;
  localparam int MAXC  = 40;

  // clock / reset
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  logic          start = 1'b0;
  logic          kill  = 1'b0;
  logic [2:0]    op_i  = '0;
  logic [W-1:0]  a_i   = '0;
  logic [CW-1:0] amt_i = '0;

  logic [1:0]   busy_v, done_v, carry_v, zero_v, neg_v;
  logic [W-1:0] result_v [2];
  logic [1:0]   state_v  [2];

  int steps [2] = '{1, 4};

  iterative_shift_unit #(.WIDTH(W), .STEP(1)) u_dut_s1 (
    .clock(clock), .clear(clear), .start(start), .kill(kill),
    .op(op_i), .a(a_i), .amt(amt_i),
    .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0]),
    .carry(carry_v[0]), .zero(zero_v[0]), .neg(neg_v[0]),
    .dbg_state(state_v[0])
  );

  iterative_shift_unit #(.WIDTH(W), .STEP(4)) u_dut_s4 (
    .clock(clock), .clear(clear), .start(start), .kill(kill),
    .op(op_i), .a(a_i), .amt(amt_i),
    .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1]),
    .carry(carry_v[1]), .zero(zero_v[1]), .neg(neg_v[1]),
    .dbg_state(state_v[1])
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: shift a by k bits in one go.
  task automatic ref_shift(input logic [2:0] o, input logic [W-1:0] av,
                           input int k, output logic [W-1:0] res,
                           output logic car);
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] tmp;
    dbl = {av, av};
    res = av;
    car = 1'b0;
    case (o)
      3'd0: begin
        res = av >> k;
        if (k > 0) car = av[k-1];
      end
      3'd1: begin
        res = $signed(av) >>> k;
        if (k > 0) car = av[k-1];
      end
      3'd2: begin
        res = av << k;
        if (k > 0) car = av[W-k];
      end
      3'd3: begin
        tmp = dbl >> k;
        res = tmp[W-1:0];
      end
      3'd4: begin
        tmp = dbl << k;
        res = tmp[2*W-1:W];
      end
      default: begin
        res = av;
      end
    endcase
  endtask

  // Launch one operation on both instances and check the whole episode.
  // kill_at / clear_at: assert that input during the given cycle after the
  // start edge (cycle 1 is the first cycle after the start edge); 0 = never.
  // hold: keep start high through cycle 1 as well.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] av,
                       input int n, input int kill_at, input int clear_at,
                       input bit hold);
    int busy_cnt [2];
    int done_cnt [2];
    int done_cyc [2];
    int nn, total, k, bits;
    bit aborted;
    logic [W-1:0] exp_res;
    logic exp_car;
    string tg;

    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
    end
    @(negedge clock);
    op_i  = o;
    a_i   = av;
    amt_i = CW'(n);
    start = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clock);
      kill  = 1'b0;
      clear = 1'b0;
      if (!hold || c >= 2) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (busy_v[i]) busy_cnt[i]++;
        if (done_v[i]) begin
          done_cnt[i]++;
          done_cyc[i] = c;
        end
      end
      if (c == kill_at)  kill  = 1'b1;
      if (c == clear_at) clear = 1'b1;
    end

    nn = (o <= 3'd4) ? n : 0;
    k  = (clear_at > 0) ? clear_at : kill_at;
    for (int i = 0; i < 2; i++) begin
      total   = (nn + steps[i] - 1) / steps[i];
      aborted = (k > 0) && (k <= total);
      bits    = aborted ? (((k - 1) * steps[i] < nn) ? (k - 1) * steps[i] : nn) : nn;
      if (clear_at > 0 && aborted) begin
        exp_res = '0;
        exp_car = 1'b0;
      end else begin
        ref_shift(o, av, bits, exp_res, exp_car);
      end
      tg = $sformatf("op%0d_a%08h_n%0d_s%0d", o, av, n, steps[i]);
      check({tg, "_result"}, result_v[i], exp_res);
      check({tg, "_carry"},  W'(carry_v[i]), W'(exp_car));
      check({tg, "_zero"},   W'(zero_v[i]),  W'(exp_res == '0));
      check({tg, "_neg"},    W'(neg_v[i]),   W'(exp_res[W-1]));
      check({tg, "_busy_cycles"}, W'(busy_cnt[i]), W'(aborted ? k : total));
      check({tg, "_done_count"},  W'(done_cnt[i]), W'(aborted ? 0 : 1));
      if (!aborted)
        check({tg, "_done_cycle"}, W'(done_cyc[i]), W'(total + 1));
      check({tg, "_state_idle"}, W'(state_v[i]), W'(0));
    end
  endtask

  initial begin
    // reset
    clear = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_result_%0d", i), result_v[i], '0);
      check($sformatf("reset_busy_%0d", i),   W'(busy_v[i]),  W'(0));
      check($sformatf("reset_done_%0d", i),   W'(done_v[i]),  W'(0));
      check($sformatf("reset_carry_%0d", i),  W'(carry_v[i]), W'(0));
      check($sformatf("reset_zero_%0d", i),   W'(zero_v[i]),  W'(1));
      check($sformatf("reset_state_%0d", i),  W'(state_v[i]), W'(0));
    end
    clear = 1'b0;

    // directed cases with literal expectations on the STEP=1 instance
    do_op(3'd1, 32'hFFFF_FFFF, 2, 0, 0, 1'b0);
    check("tp_shra_ff_res", result_v[0], 32'hFFFF_FFFF);
    check("tp_shra_ff_car", W'(carry_v[0]), W'(1));
    do_op(3'd1, 32'h8000_0010, 4, 0, 0, 1'b0);
    check("tp_shra_80_res", result_v[0], 32'hF800_0001);
    do_op(3'd0, 32'h8000_0010, 4, 0, 0, 1'b0);
    check("tp_shr_80_res", result_v[0], 32'h0800_0001);
    do_op(3'd0, 32'h0000_000F, 2, 0, 0, 1'b0);
    check("tp_shr_0f_res", result_v[0], 32'h0000_0003);
    check("tp_shr_0f_car", W'(carry_v[0]), W'(1));
    do_op(3'd4, 32'h8000_0001, 1, 0, 0, 1'b0);
    check("tp_rol_res", result_v[0], 32'h0000_0003);
    do_op(3'd3, 32'h0000_0001, 4, 0, 0, 1'b0);
    check("tp_ror_res", result_v[0], 32'h1000_0000);
    do_op(3'd2, 32'h0000_0001, 31, 0, 0, 1'b0);
    check("tp_shl1_s4_res", result_v[1], 32'h8000_0000);
    check("tp_shl1_s4_car", W'(carry_v[1]), W'(0));
    do_op(3'd2, 32'h0000_0003, 31, 0, 0, 1'b0);
    check("tp_shl3_s4_car", W'(carry_v[1]), W'(1));

    // zero-length and illegal ops, with start held into the DONE cycle
    do_op(3'd0, 32'h1234_5678, 0, 0, 0, 1'b1);
    do_op(3'd7, 32'hDEAD_BEEF, 9, 0, 0, 1'b1);
    do_op(3'd5, 32'h0000_0000, 3, 0, 0, 1'b0);

    // aborts, each followed by a fresh operation
    do_op(3'd0, 32'hA5A5_F00F, 20, 5, 0, 1'b0);
    do_op(3'd2, 32'h0000_00FF, 7, 0, 0, 1'b0);
    do_op(3'd0, 32'hA5A5_F00F, 20, 0, 3, 1'b0);
    do_op(3'd3, 32'h1234_5678, 9, 0, 0, 1'b0);
    // kill during the STEP=1 done cycle: pulse must still complete
    do_op(3'd0, 32'hFFFF_0000, 20, 21, 0, 1'b0);
    // kill on the very first busy cycle
    do_op(3'd1, 32'h8765_4321, 13, 1, 0, 1'b0);

    // randomized operations
    for (int t = 0; t < 150; t++) begin
      logic [2:0] o;
      int kat;
      o   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                        : 3'($urandom_range(0, 4));
      kat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : 0;
      do_op(o, $urandom, int'($urandom_range(0, W - 1)), kat, 0,
            1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
